draw_processor: RTL and testbench
=================================

// Module: draw_processor
// PURPOSE
//  Drawing instruction executor that sits downstream of the drawing sequencers (background
//  fill, sprite drawers). Accepts one 32-bit instruction per start/finished handshake and
//  converts it into per-pixel writes on the VGA adapter port (x, y, colour, plot).
//  Multi-pixel ops (HLINE, CLEAR) are expanded internally, one pixel per clock.
// PARAMETERS
//  SCREEN_WIDTH   160  visible columns
//  SCREEN_HEIGHT  120  visible rows
//  X_W            8    x coordinate width
//  Y_W            7    y coordinate width
//  C_W            3    colour width
//  RESULT_W       16   result width
//  INSTR_W        32   fixed = 4+9+1+C_W+Y_W+X_W
// PORTS
//  clock        in   1         system clock, rising edge
//  resetn       in   1         asynchronous reset, active-low
//  start        in   1         instruction strobe; sampled only while finished=1
//  instruction  in   INSTR_W   {op[3:0], arg[8:0], plot, colour, y, x}
//  finished     out  1         1 = idle, ready to accept; result valid
//  result       out  RESULT_W  pixels written by the last instruction; 16'hFFFF = bad opcode
//  vga_x        out  X_W       pixel x to adapter
//  vga_y        out  Y_W       pixel y to adapter
//  vga_colour   out  C_W       pixel colour to adapter
//  vga_plot     out  1         write enable to adapter, one pixel per cycle
// BEHAVIOUR
//  - Reset (async, resetn=0): finished=1, result=0, vga_x/vga_y/vga_colour=0, vga_plot=0,
//    state=IDLE. Reset mid-instruction aborts it; no further pixels are written.
//  - All outputs are registered. Opcodes: 0 NOP, 1 PLOT, 2 HLINE (arg = length), 3 CLEAR.
//    Opcodes 4-15 are illegal.
//  - Handshake: start seen in IDLE at edge N -> instruction latched, finished=0 from N+1.
//    Caller samples finished no earlier than N+2. start while finished=0 is ignored (no queue).
//  - States: IDLE -> {PLOT | HLINE | CLEAR | DONE} -> DONE -> IDLE. DONE asserts finished=1,
//    updates result, and holds vga_plot=0.
//  - NOP: N+1 DONE, finished=1 at N+2, result=0.
//  - PLOT: N+1 drive x, y, colour, vga_plot=plot bit. finished=1 at N+2.
//    result = 1 if plot bit set, else 0.
//  - HLINE: L=arg (0..511). Pixels (x+i, y) for i=0..L-1 on cycles N+1..N+L.
//    finished=1 at N+L+1. L=0 -> no pixels, finished at N+2, result=0.
//    x increment is X_W-bit modulo (wraps 255->0).
//  - CLEAR: writes colour to every (x,y), x fastest, 0..SCREEN_WIDTH-1 then y++,
//    through (SCREEN_WIDTH-1, SCREEN_HEIGHT-1). Instruction x/y fields ignored.
//    finished=1 at N+SCREEN_WIDTH*SCREEN_HEIGHT+1. result = 19200 with default params.
//  - Plot bit = 0: timing is identical, vga_plot stays 0, result=0.
//  - result counts asserted vga_plot cycles, saturating at all-ones-1 (16'hFFFE).
//  - Illegal opcode: no pixels written, finished at N+2, result=16'hFFFF.
//  - vga_x/vga_y/vga_colour hold their last driven value while vga_plot=0.
// CONFIGURATION
//  DRAW_PROC_CLIP_EN defined: any pixel with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT has
//    vga_plot forced to 0 and is not counted in result. Cycle timing is unchanged.
//  Not defined: coordinates pass to the adapter unclipped and every pixel is counted.
// TESTING
//  1. Reset, then start PLOT {1,0,1,3'b101,y=7,x=9} -> N+1: vga_plot=1, (9,7), colour 5;
//     N+2: finished=1, result=1.
//  2. HLINE x=10, y=3, L=5, plot=1 -> plots at x=10..14 on cycles N+1..N+5;
//     finished at N+6; result=5.
//  3. CLEAR colour=3'b010 -> 19200 plots, last (159,119); finished at N+19201;
//     start pulsed mid-run is ignored.
//  4. HLINE x=158, L=4 -> clip EN: only x=158,159 plotted, result=2;
//     clip off: x=158,159,160,161 plotted, result=4.
//  5. Opcode 7 -> no vga_plot, result=16'hFFFF at N+2. PLOT with plot bit=0 -> result=0.
//  6. resetn low during CLEAR -> outputs reach reset values immediately (async);
//     after release finished=1 and no pixels are written.

Source files
------------

// File: rtl/draw_processor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : draw_processor_if                                             |
// | Purpose  : Instruction handshake and VGA adapter pixel bus               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface draw_processor_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int RESULT_W = 16
);
    localparam int INSTR_W = 4 + 9 + 1 + C_W + Y_W + X_W;

    logic                start;
    logic [INSTR_W-1:0]  instruction;
    logic                finished;
    logic [RESULT_W-1:0] result;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [C_W-1:0]      vga_colour;
    logic                vga_plot;

    modport master (
        output start, instruction,
        input  finished, result, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, instruction,
        output finished, result, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface
`default_nettype wire

// File: rtl/draw_processor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : draw_processor                                                |
// | Purpose  : Executes NOP/PLOT/HLINE/CLEAR drawing instructions as one     |
// |            pixel write per clock. Optional DRAW_PROC_CLIP_EN suppresses  |
// |            off-screen pixels.                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module draw_processor #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int C_W           = 3,
    parameter int RESULT_W      = 16
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    draw_processor_if.slave   bus
);
    localparam int INSTR_W = 4 + 9 + 1 + C_W + Y_W + X_W;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PLOT  = 4'd1;
    localparam logic [3:0] OP_HLINE = 4'd2;
    localparam logic [3:0] OP_CLEAR = 4'd3;

    localparam logic [X_W-1:0]      X_MAX   = X_W'(SCREEN_WIDTH - 1);
    localparam logic [Y_W-1:0]      Y_MAX   = Y_W'(SCREEN_HEIGHT - 1);
    localparam logic [RESULT_W-1:0] CNT_SAT = {{(RESULT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLOT  = 3'd1,
        S_HLINE = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                finished_q, finished_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [C_W-1:0]      vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d;
    logic [8:0]          len_q, len_d;
    logic                plot_en_q, plot_en_d;
    logic                err_q, err_d;
    logic [RESULT_W-1:0] pix_cnt_q, pix_cnt_d;

    logic                emit;
    logic [X_W-1:0]      emit_x;
    logic [Y_W-1:0]      emit_y;
    logic                cnt_clr;
    logic                in_view;
    logic [RESULT_W-1:0] pix_base;

    wire logic [3:0]     in_op     = bus.instruction[INSTR_W-1 -: 4];
    wire logic [8:0]     in_arg    = bus.instruction[INSTR_W-5 -: 9];
    wire logic           in_plot   = bus.instruction[C_W+Y_W+X_W];
    wire logic [C_W-1:0] in_colour = bus.instruction[X_W+Y_W +: C_W];
    wire logic [Y_W-1:0] in_y      = bus.instruction[X_W +: Y_W];
    wire logic [X_W-1:0] in_x      = bus.instruction[0 +: X_W];

    // The first pixel of an op is issued on the accepting edge, so every op
    // reports finished one edge after its last pixel.
    always_comb begin
        state_d      = state_q;
        finished_d   = finished_q;
        result_d     = result_q;
        vga_colour_d = vga_colour_q;
        len_d        = len_q;
        plot_en_d    = plot_en_q;
        err_d        = err_q;
        emit         = 1'b0;
        emit_x       = vga_x_q;
        emit_y       = vga_y_q;
        cnt_clr      = 1'b0;

        if (finished_q && bus.start) begin
            finished_d = 1'b0;
            cnt_clr    = 1'b1;
            err_d      = 1'b0;
            plot_en_d  = in_plot;
            case (in_op)
                OP_NOP: state_d = S_DONE;
                OP_PLOT: begin
                    state_d      = S_PLOT;
                    vga_colour_d = in_colour;
                    emit         = 1'b1;
                    emit_x       = in_x;
                    emit_y       = in_y;
                end
                OP_HLINE: begin
                    if (in_arg == 9'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_HLINE;
                        vga_colour_d = in_colour;
                        emit         = 1'b1;
                        emit_x       = in_x;
                        emit_y       = in_y;
                        len_d        = in_arg - 9'd1;
                    end
                end
                OP_CLEAR: begin
                    state_d      = S_CLEAR;
                    vga_colour_d = in_colour;
                    emit         = 1'b1;
                    emit_x       = '0;
                    emit_y       = '0;
                end
                default: begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                S_PLOT: state_d = S_DONE;
                S_HLINE: begin
                    if (len_q == 9'd0) begin
                        state_d = S_DONE;
                    end else begin
                        emit   = 1'b1;
                        emit_x = vga_x_q + X_W'(1);
                        len_d  = len_q - 9'd1;
                    end
                end
                S_CLEAR: begin
                    if (vga_x_q == X_MAX && vga_y_q == Y_MAX) begin
                        state_d = S_DONE;
                    end else if (vga_x_q == X_MAX) begin
                        emit   = 1'b1;
                        emit_x = '0;
                        emit_y = vga_y_q + Y_W'(1);
                    end else begin
                        emit   = 1'b1;
                        emit_x = vga_x_q + X_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            // Any exit from an active state publishes the result exactly once.
            if (state_q != S_IDLE && !finished_q) begin
                if (state_d == S_DONE || state_d == S_IDLE) begin
                    finished_d = 1'b1;
                    result_d   = err_q ? {RESULT_W{1'b1}} : pix_cnt_q;
                end
            end
        end
    end

`ifdef DRAW_PROC_CLIP_EN
    localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_WIDTH);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_HEIGHT);
    assign in_view = (emit_x < X_LIM) && (emit_y < Y_LIM);
`else
    assign in_view = 1'b1;
`endif

    always_comb begin
        vga_x_d    = emit ? emit_x : vga_x_q;
        vga_y_d    = emit ? emit_y : vga_y_q;
        vga_plot_d = emit && plot_en_d && in_view;
        pix_base   = cnt_clr ? '0 : pix_cnt_q;
        pix_cnt_d  = pix_base;
        if (vga_plot_d && pix_base != CNT_SAT) begin
            pix_cnt_d = pix_base + RESULT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            finished_q   <= 1'b1;
            result_q     <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            len_q        <= '0;
            plot_en_q    <= 1'b0;
            err_q        <= 1'b0;
            pix_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            finished_q   <= finished_d;
            result_q     <= result_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            len_q        <= len_d;
            plot_en_q    <= plot_en_d;
            err_q        <= err_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    assign bus.finished   = finished_q;
    assign bus.result     = result_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
endmodule
`default_nettype wire

// File: tb/tb_draw_processor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_draw_processor                                             |
// | Purpose  : Directed self-checking bench for draw_processor               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_draw_processor;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int RESULT_W = 16;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    draw_processor_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .RESULT_W(RESULT_W)) bus ();

    draw_processor #(
        .SCREEN_WIDTH  (160),
        .SCREEN_HEIGHT (120),
        .X_W           (X_W),
        .Y_W           (Y_W),
        .C_W           (C_W),
        .RESULT_W      (RESULT_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [8:0] arg,
                                       input logic p, input logic [2:0] c,
                                       input logic [6:0] y, input logic [7:0] x);
        return {op, arg, p, c, y, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1ns after the accepting edge N, i.e. viewing cycle N+1.
    task automatic issue(input logic [31:0] ins);
        @(negedge clock);
        bus.start       = 1'b1;
        bus.instruction = ins;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic short_op(input string tag, input logic [31:0] ins,
                            input logic exp_plot, input logic [15:0] exp_res);
        issue(ins);
        chk({tag, "_plot1"}, bus.vga_plot, exp_plot);
        chk({tag, "_busy"}, bus.finished, 1'b0);
        step();
        chk({tag, "_fin"}, bus.finished, 1'b1);
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_plot2"}, bus.vga_plot, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          n_pix;
        int          order_err;
        int          col_err;
        int          stray;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [7:0]  last_x;
        logic [6:0]  last_y;
        logic [3:0]  mask;

        bus.start       = 1'b0;
        bus.instruction = '0;
        last_x = '0;
        last_y = '0;
        mask   = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_finished", bus.finished, 1'b1);
        chk("rst_result", bus.result, 16'h0);
        chk("rst_plot", bus.vga_plot, 1'b0);
        chk("rst_x", bus.vga_x, 8'd0);
        chk("rst_y", bus.vga_y, 7'd0);
        chk("rst_colour", bus.vga_colour, 3'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Single PLOT
        issue(mk(4'd1, 9'd0, 1'b1, 3'b101, 7'd7, 8'd9));
        chk("plot_vld", bus.vga_plot, 1'b1);
        chk("plot_x", bus.vga_x, 8'd9);
        chk("plot_y", bus.vga_y, 7'd7);
        chk("plot_col", bus.vga_colour, 3'd5);
        chk("plot_busy", bus.finished, 1'b0);
        step();
        chk("plot_fin", bus.finished, 1'b1);
        chk("plot_res", bus.result, 16'd1);
        chk("plot_off", bus.vga_plot, 1'b0);

        // HLINE x=10 y=3 L=5
        issue(mk(4'd2, 9'd5, 1'b1, 3'd2, 7'd3, 8'd10));
        for (int i = 0; i < 5; i++) begin
            chk("hline_plot", bus.vga_plot, 1'b1);
            chk("hline_x", bus.vga_x, 32'(10 + i));
            chk("hline_y", bus.vga_y, 7'd3);
            chk("hline_busy", bus.finished, 1'b0);
            step();
        end
        chk("hline_fin", bus.finished, 1'b1);
        chk("hline_res", bus.result, 16'd5);
        chk("hline_off", bus.vga_plot, 1'b0);

        // CLEAR with a stray start mid-run
        issue(mk(4'd3, 9'd0, 1'b1, 3'b010, 7'd50, 8'd77));
        k = 0; n_pix = 0; order_err = 0; col_err = 0; ex = '0; ey = '0;
        while (!bus.finished && k < 20000) begin
            if (k == 100) begin
                bus.start       = 1'b1;
                bus.instruction = mk(4'd1, 9'd0, 1'b1, 3'd7, 7'd1, 8'd1);
            end
            if (k == 101) bus.start = 1'b0;
            if (bus.vga_plot) begin
                n_pix++;
                if (bus.vga_x !== ex || bus.vga_y !== ey) order_err++;
                if (bus.vga_colour !== 3'b010) col_err++;
                last_x = bus.vga_x;
                last_y = bus.vga_y;
                if (ex == 8'd159) begin
                    ex = '0;
                    ey = ey + 7'd1;
                end else begin
                    ex = ex + 8'd1;
                end
            end
            step();
            k++;
        end
        chk("clear_cycles", k, 19200);
        chk("clear_pixels", n_pix, 19200);
        chk("clear_order", order_err, 0);
        chk("clear_colour", col_err, 0);
        chk("clear_last_x", last_x, 8'd159);
        chk("clear_last_y", last_y, 7'd119);
        chk("clear_res", bus.result, 16'd19200);
        step();
        chk("clear_idle_plot", bus.vga_plot, 1'b0);
        chk("clear_idle_fin", bus.finished, 1'b1);

        // HLINE crossing the right screen edge
        issue(mk(4'd2, 9'd4, 1'b1, 3'd3, 7'd5, 8'd158));
        for (int i = 0; i < 4; i++) begin
            mask[i] = bus.vga_plot;
            chk("edge_x", bus.vga_x, 32'(158 + i));
            step();
        end
        chk("edge_fin", bus.finished, 1'b1);
`ifdef DRAW_PROC_CLIP_EN
        chk("edge_mask", mask, 4'b0011);
        chk("edge_res", bus.result, 16'd2);
`else
        chk("edge_mask", mask, 4'b1111);
        chk("edge_res", bus.result, 16'd4);
`endif

        short_op("illegal", mk(4'd7, 9'd3, 1'b1, 3'd1, 7'd1, 8'd1), 1'b0, 16'hFFFF);
        short_op("nop", mk(4'd0, 9'd0, 1'b1, 3'd1, 7'd1, 8'd1), 1'b0, 16'h0000);
        short_op("plot_on", mk(4'd1, 9'd0, 1'b1, 3'd4, 7'd2, 8'd2), 1'b1, 16'h0001);
        short_op("hline0", mk(4'd2, 9'd0, 1'b1, 3'd4, 7'd2, 8'd2), 1'b0, 16'h0000);
        short_op("plot_on2", mk(4'd1, 9'd0, 1'b1, 3'd4, 7'd2, 8'd2), 1'b1, 16'h0001);
        short_op("plot_off", mk(4'd1, 9'd0, 1'b0, 3'd4, 7'd2, 8'd2), 1'b0, 16'h0000);

        // Asynchronous reset during CLEAR
        issue(mk(4'd3, 9'd0, 1'b1, 3'd6, 7'd0, 8'd0));
        repeat (10) step();
        chk("arst_pre_plot", bus.vga_plot, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_plot", bus.vga_plot, 1'b0);
        chk("arst_fin", bus.finished, 1'b1);
        chk("arst_res", bus.result, 16'h0);
        chk("arst_x", bus.vga_x, 8'd0);
        chk("arst_col", bus.vga_colour, 3'd0);
        @(negedge clock);
        resetn = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.vga_plot !== 1'b0) stray++;
        end
        chk("arst_no_pixels", stray, 0);
        chk("arst_idle", bus.finished, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
